// File: rtl/mips_pkg.sv
// Shared types for the mips_cpu_harvard HI/LO multiply/divide unit.
//   muldiv_op_t    : operation code presented on the unit's op port
//   muldiv_state_t : sequencing states of the HI/LO unit
//   MULDIV_ITER    : iterations per multiply/divide (one result bit per step)
package mips_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } muldiv_state_t;

  localparam int MULDIV_ITER = 32;

endpackage

// File: rtl/mips_muldiv_core.sv
// Unsigned iterative datapath: 32-step shift-add multiply or restoring divide.
//   clk_i/rst_ni : clock, async active-low reset
//   en_i         : 0 holds every register
//   load_i       : capture a_i/b_i/div_i and clear the step counter
//   step_i       : perform one iteration
//   div_i        : 1 = divide (a_i / b_i), 0 = multiply (a_i * b_i)
//   cnt_o        : iterations completed since load
//   hi_o/lo_o    : product {hi,lo}, or remainder (hi) and quotient (lo)
module mips_muldiv_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum, rsh;
  logic [WIDTH+1:0] diff;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    div_d = div_q;
    cnt_d = cnt_q;
    sum   = '0;
    rsh   = '0;
    diff  = '0;
    if (load_i) begin
      // lo holds the multiplier (consumed from bit 0) or the dividend
      // (consumed from the top bit); hi accumulates product/remainder.
      hi_d  = '0;
      lo_d  = a_i;
      b_d   = b_i;
      div_d = div_i;
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (div_q) begin
        rsh  = {hi_q, lo_q[WIDTH-1]};
        diff = {1'b0, rsh} - {2'b00, b_q};
        if (!diff[WIDTH+1]) begin
          hi_d = diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = rsh[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        sum          = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (en_i) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign hi_o  = hi_q;
  assign lo_o  = lo_q;

endmodule

// File: rtl/mips_muldiv_unit.sv
// HI/LO multiply/divide unit for the execute stage (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
//   clk, reset (async, active low), clk_enable (0 holds all state)
//   start/op/rs_data/rt_data : issue; ignored while busy or for unknown op codes
//   busy : operation in flight; done : 1-cycle pulse when HI/LO take a result
//   hi/lo : architectural HI and LO registers
// Signed operations run on magnitudes in the unsigned core; signs are
// restored in FINISH.
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t    state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_q, div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, dz_q, dz_d;

  logic             is_md, is_sgn, is_div, core_load, core_step;
  logic [WIDTH-1:0] a_mag, b_mag, core_hi, core_lo;
  logic [CNT_W-1:0] core_cnt;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    is_md  = 1'b0;
    is_sgn = 1'b0;
    is_div = 1'b0;
    case (op)
      MULT:  begin is_md = 1'b1; is_sgn = 1'b1; end
      MULTU: is_md = 1'b1;
      DIV:   begin is_md = 1'b1; is_sgn = 1'b1; is_div = 1'b1; end
      DIVU:  begin is_md = 1'b1; is_div = 1'b1; end
      default: ;
    endcase
  end

  assign a_mag     = (is_sgn && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign b_mag     = (is_sgn && rt_data[WIDTH-1]) ? -rt_data : rt_data;
  assign core_load = (state_q == IDLE) && start && is_md;
  assign core_step = (state_q == RUN);

  mips_muldiv_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (clk_enable),
    .load_i (core_load),
    .step_i (core_step),
    .div_i  (is_div),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .cnt_o  (core_cnt),
    .hi_o   (core_hi),
    .lo_o   (core_lo)
  );

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    prod      = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_md) begin
            state_d   = RUN;
            div_d     = is_div;
            neg_res_d = is_sgn && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_rem_d = is_sgn && rs_data[WIDTH-1];
            dz_d      = is_div && (rt_data == '0);
          end else if (op == MTHI) begin
            hi_d = rs_data;
          end else if (op == MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      RUN: begin
        // the step taken on this edge is the final one
        if (core_cnt == CNT_W'(MULDIV_ITER - 1)) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          // divide-by-zero: core leaves |rs| as remainder, and restoring the
          // dividend sign returns rs itself; the quotient is forced all-ones
          hi_d = neg_rem_q ? -core_hi : core_hi;
          lo_d = dz_q ? '1 : (neg_res_q ? -core_lo : core_lo);
        end else begin
          prod         = neg_res_q ? -{core_hi, core_lo} : {core_hi, core_lo};
          {hi_d, lo_d} = prod;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else if (clk_enable) begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: issued mul/div ops push the
// reference {hi,lo} and the edge at which done must appear; a negedge
// monitor pops and compares on every done pulse.
module tb_mips_muldiv_unit;
  import mips_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, clk_enable = 1'b1, start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_data = '0, rt_data = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  mips_muldiv_unit dut (
    .clk(clk), .reset(rst_n), .clk_enable(clk_enable), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  typedef struct { logic [63:0] res; int due; } exp_t;
  exp_t sb_q[$];
  exp_t e_mon;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  // Reference: architectural results from plain integer arithmetic.
  function automatic logic [63:0] ref_md(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    int sa, sb;
    longint p;
    sa = a; sb = b;
    case (o)
      3'd0: begin p = longint'(sa) * longint'(sb); return p; end
      3'd1: return {32'h0, a} * {32'h0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: hi=%h lo=%h at edge %0d", hi, lo, edge_cnt);
      end else begin
        e_mon = sb_q.pop_front();
        chk("result", {hi, lo}, e_mon.res);
        chk("done_edge", 64'(edge_cnt), 64'(e_mon.due));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one op at the next edge (E0). hold = disabled edges planned inside
  // the run; track=0 for ops that will be aborted.
  task automatic issue(logic [2:0] o, logic [31:0] a, logic [31:0] b, int hold, bit track);
    exp_t e;
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    tick();
    start = 1'b0;
    if (o <= 3'd3 && track) begin
      e.res = ref_md(o, a, b);
      e.due = edge_cnt + 33 + hold;
      sb_q.push_back(e);
      {m_hi, m_lo} = e.res;
    end else if (o == 3'd4) m_hi = a;
    else if (o == 3'd5) m_lo = a;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin tick(); n++; end
    if (busy) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: busy still high after %0d cycles", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [2:0]  o;
    logic [31:0] a, b;
    #12;
    chk("reset_state", {busy, done, hi, lo}, 64'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // MULT -2*3 with busy window E1..E32, done after E33
    issue(3'd0, 32'hFFFF_FFFE, 32'd3, 0, 1);
    bad = 0;
    for (int i = 0; i < 32; i++) begin tick(); if (!busy) bad++; end
    chk("busy_window", 64'(bad), 64'h0);
    tick();
    chk("busy_done_e33", {busy, done}, 2'b01);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    // issued in the done cycle
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
    wait_idle();
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 1);
    wait_idle();
    chk("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(3'd3, 32'd7, 32'd0, 0, 1);
    wait_idle();
    chk("divu_by0", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
    wait_idle();
    chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    issue(3'd2, 32'hFFFF_FFF3, 32'd0, 0, 1);
    wait_idle();
    chk("div_by0_neg", {hi, lo}, 64'hFFFF_FFF3_FFFF_FFFF);

    issue(3'd4, 32'h1234_5678, 32'h0, 0, 1);
    chk("mthi", {busy, done, hi}, {2'b00, 32'h1234_5678});
    issue(3'd5, 32'hCAFE_F00D, 32'h0, 0, 1);
    chk("mtlo", {busy, done, lo}, {2'b00, 32'hCAFE_F00D});

    // start while busy is ignored
    issue(3'd0, 32'h0001_2345, 32'hFFFF_0F0F, 0, 1);
    repeat (4) tick();
    op = 3'd3; rs_data = 32'd9; rt_data = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();
    chk("ignored_start", {hi, lo}, ref_md(3'd0, 32'h0001_2345, 32'hFFFF_0F0F));

    // reset mid-operation aborts without done
    issue(3'd2, 32'd100, 32'd7, 0, 0);
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_reset", {busy, done, hi, lo}, 64'h0);
    m_hi = '0; m_lo = '0;
    @(negedge clk) rst_n = 1'b1;
    repeat (40) tick();

    // clk_enable low for 5 edges during RUN
    issue(3'd0, 32'h8765_4321, 32'h0BAD_BEEF, 5, 1);
    repeat (10) tick();
    clk_enable = 1'b0;
    repeat (5) tick();
    clk_enable = 1'b1;
    wait_idle();
    chk("stall_result", {hi, lo}, ref_md(3'd0, 32'h8765_4321, 32'h0BAD_BEEF));

    // randomized ops, including invalid codes
    repeat (40) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = 32'($urandom_range(1, 16));
        2: a = 32'($urandom_range(0, 1000));
        3: b = -32'($urandom_range(1, 16));
        default: ;
      endcase
      issue(o, a, b, 0, 1);
      if (o <= 3'd3) wait_idle();
      else chk("idle_op", {busy, done, hi, lo}, {2'b00, m_hi, m_lo});
    end

    repeat (3) tick();
    chk("sb_drained", 64'(sb_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
